// File: rtl/axi_master_req_arbiter.sv
// Two-port request arbiter in front of a single-beat AXI read/write FSM pair.
// Optional watchdog: define ARB_TIMEOUT_EN to abort stalled transactions.
module axi_master_req_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int ID_BASE     = 0,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W/8-1:0] req0_wstrb,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_gnt,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W/8-1:0] req1_wstrb,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_gnt,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              m_read_signal,
  output logic              m_write_signal,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0] m_wdata,
  output logic [ID_W-1:0]   m_id,
  input  logic              m_rd_busy,
  input  logic              m_wr_busy,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_bdone
);

  localparam int SW = DATA_W / 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;
  localparam logic [1:0] WAIT_WR = 2'd3;

  logic [1:0]        state;
  logic              owner;
  logic              rr_ptr;
  logic              is_wr;
  logic              fin;

  logic              go;
  logic              win;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [SW-1:0]     s_wstrb;
  logic [DATA_W-1:0] s_wdata;

  always_comb begin
    go      = (req0_valid | req1_valid) & ~m_rd_busy & ~m_wr_busy;
    win     = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
    s_wr    = win ? req1_write : req0_write;
    s_addr  = win ? req1_addr  : req0_addr;
    s_wstrb = win ? req1_wstrb : req0_wstrb;
    s_wdata = win ? req1_wdata : req0_wdata;
  end

  assign req0_gnt       = (state == ISSUE) & ~owner;
  assign req1_gnt       = (state == ISSUE) &  owner;
  assign m_write_signal = (state == ISSUE) &  is_wr;
  assign m_read_signal  = (state == ISSUE) & ~is_wr;
  assign req0_done      = fin & ~owner;
  assign req1_done      = fin &  owner;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic          tmo;
  logic          fin_err;

  assign tmo      = (cnt == CW'(TIMEOUT_CYC - 1));
  assign req0_err = fin_err & ~owner;
  assign req1_err = fin_err &  owner;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT_RD || state == WAIT_WR) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign req0_err = 1'b0;
  assign req1_err = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      is_wr      <= 1'b0;
      fin        <= 1'b0;
      m_addr     <= '0;
      m_wstrb    <= '0;
      m_wdata    <= '0;
      m_id       <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
      fin_err    <= 1'b0;
`endif
    end else begin
      fin <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      fin_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (go) begin
            state   <= ISSUE;
            owner   <= win;
            rr_ptr  <= ~win;
            is_wr   <= s_wr;
            m_addr  <= s_addr;
            m_wstrb <= s_wr ? s_wstrb : '0;
            m_wdata <= s_wr ? s_wdata : '0;
            m_id    <= ID_W'(ID_BASE) + ID_W'(win);
          end
        end
        ISSUE: begin
          state <= is_wr ? WAIT_WR : WAIT_RD;
        end
        WAIT_RD: begin
          if (m_rvalid && m_rlast) begin
            state <= IDLE;
            fin   <= 1'b1;
            if (owner) req1_rdata <= m_rdata;
            else       req0_rdata <= m_rdata;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo) begin
            state   <= IDLE;
            fin     <= 1'b1;
            fin_err <= 1'b1;
          end
`endif
        end
        WAIT_WR: begin
          if (m_bdone) begin
            state <= IDLE;
            fin   <= 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo) begin
            state   <= IDLE;
            fin     <= 1'b1;
            fin_err <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
